seq_divider: RTL and testbench

- Parametrised successor to the team's fixed 8-bit iterative divider.
- Radix-2 restoring division, one quotient bit per clock.
- Adds: runtime signed/unsigned mode, an explicit Busy/Done handshake, divide-by-zero detection, and back-to-back request acceptance.
- Sits beside the control/datapath pair as a self-contained arithmetic unit for wider operands.

---
 rtl/divider_pkg.sv | 27 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential radix-2 restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned MAX_OPERAND_W = 64;

    // Divide-by-zero quotient; each instance slices off its own width.
    localparam logic [MAX_OPERAND_W-1:0] DBZ_QUOTIENT = '1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, trial-subtract the divisor, restore on borrow.
module div_step
    import divider_pkg::*;
#(
    parameter int unsigned OPERAND_W = 8
) (
    input  logic [OPERAND_W-1:0] i_rem,
    input  logic [OPERAND_W-1:0] i_dvd,
    input  logic [OPERAND_W-1:0] i_dsr,
    output logic [OPERAND_W-1:0] o_rem,
    output logic [OPERAND_W-1:0] o_dvd,
    output logic                 o_qbit
);

    logic [OPERAND_W:0] w_shifted;
    logic [OPERAND_W:0] w_diff;

    // Remainder < divisor on entry, so the top bit of the difference is exactly the borrow.
    assign w_shifted = {i_rem, i_dvd[OPERAND_W-1]};
    assign w_diff    = w_shifted - {1'b0, i_dsr};
    assign o_qbit    = ~w_diff[OPERAND_W];
    assign o_rem     = o_qbit ? w_diff[OPERAND_W-1:0] : w_shifted[OPERAND_W-1:0];
    assign o_dvd     = {i_dvd[OPERAND_W-2:0], 1'b0};

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider: one quotient bit per clock, Busy/Done handshake,
// divide-by-zero flag and back-to-back acceptance in the Done cycle.
module seq_divider
    import divider_pkg::*;
#(
    parameter int unsigned OPERAND_W = 8,
    parameter int unsigned CNT_W     = clog2(OPERAND_W) + 1
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Req,
    input  logic                 Signed,
    input  logic [OPERAND_W-1:0] Operand1,
    input  logic [OPERAND_W-1:0] Operand2,
    output logic [OPERAND_W-1:0] Quotient,
    output logic [OPERAND_W-1:0] Remainder,
    output logic                 Done,
    output logic                 Busy,
    output logic                 DivByZero
);

    localparam logic [OPERAND_W-1:0] DBZ_Q    = DBZ_QUOTIENT[OPERAND_W-1:0];
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(OPERAND_W - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [OPERAND_W-1:0]   r_rem,   w_rem_nxt;
    logic [OPERAND_W-1:0]   r_dvd,   w_dvd_nxt;
    logic [OPERAND_W-1:0]   r_dsr,   w_dsr_nxt;
    logic                   r_qneg,  w_qneg_nxt;
    logic                   r_rneg,  w_rneg_nxt;
    logic [CNT_W-1:0]       r_cnt,   w_cnt_nxt;
    logic [OPERAND_W-1:0]   r_quot,  w_quot_nxt;
    logic [OPERAND_W-1:0]   r_remd,  w_remd_nxt;
    logic                   r_done,  w_done_nxt;
    logic                   r_busy,  w_busy_nxt;
    logic                   r_dbz,   w_dbz_nxt;

    logic                   w_sign1;
    logic                   w_sign2;
    logic [OPERAND_W-1:0]   w_mag1;
    logic [OPERAND_W-1:0]   w_mag2;
    logic                   w_div_zero;

    logic [OPERAND_W-1:0]   w_step_rem;
    logic [OPERAND_W-1:0]   w_step_dvd;
    logic                   w_step_qbit;
    logic [OPERAND_W-1:0]   w_step_quot;
    logic [OPERAND_W-1:0]   w_q_final;
    logic [OPERAND_W-1:0]   w_r_final;

    // Operand magnitudes and result signs for a request presented this cycle.
    assign w_sign1    = Signed & Operand1[OPERAND_W-1];
    assign w_sign2    = Signed & Operand2[OPERAND_W-1];
    assign w_mag1     = w_sign1 ? (~Operand1 + OPERAND_W'(1)) : Operand1;
    assign w_mag2     = w_sign2 ? (~Operand2 + OPERAND_W'(1)) : Operand2;
    assign w_div_zero = (Operand2 == '0);

    div_step #(
        .OPERAND_W (OPERAND_W)
    ) u_div_step (
        .i_rem  (r_rem),
        .i_dvd  (r_dvd),
        .i_dsr  (r_dsr),
        .o_rem  (w_step_rem),
        .o_dvd  (w_step_dvd),
        .o_qbit (w_step_qbit)
    );

    // Dividend bits leave at the top while quotient bits fill in at the bottom.
    assign w_step_quot = w_step_dvd | {{(OPERAND_W-1){1'b0}}, w_step_qbit};
    assign w_q_final   = r_qneg ? (~w_step_quot + OPERAND_W'(1)) : w_step_quot;
    assign w_r_final   = r_rneg ? (~w_step_rem  + OPERAND_W'(1)) : w_step_rem;

    // Results are produced on the edge entering FINISH so they are valid alongside Done.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_dvd_nxt   = r_dvd;
        w_dsr_nxt   = r_dsr;
        w_qneg_nxt  = r_qneg;
        w_rneg_nxt  = r_rneg;
        w_cnt_nxt   = r_cnt;
        w_quot_nxt  = r_quot;
        w_remd_nxt  = r_remd;
        w_dbz_nxt   = r_dbz;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;

        case (r_state)
            IDLE, FINISH: begin
                if (Req) begin
                    w_dvd_nxt  = w_mag1;
                    w_dsr_nxt  = w_mag2;
                    w_rem_nxt  = '0;
                    w_cnt_nxt  = '0;
                    w_qneg_nxt = w_sign1 ^ w_sign2;
                    w_rneg_nxt = w_sign1;
                    if (w_div_zero) begin
                        w_state_nxt = FINISH;
                        w_quot_nxt  = DBZ_Q;
                        w_remd_nxt  = Operand1;
                        w_dbz_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ITER;
                        w_busy_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            ITER: begin
                w_rem_nxt = w_step_rem;
                w_dvd_nxt = w_step_quot;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = FINISH;
                    w_quot_nxt  = w_q_final;
                    w_remd_nxt  = w_r_final;
                    w_dbz_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_remd <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_rem  <= w_rem_nxt;
            r_dvd  <= w_dvd_nxt;
            r_dsr  <= w_dsr_nxt;
            r_qneg <= w_qneg_nxt;
            r_rneg <= w_rneg_nxt;
            r_cnt  <= w_cnt_nxt;
            r_quot <= w_quot_nxt;
            r_remd <= w_remd_nxt;
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
            r_dbz  <= w_dbz_nxt;
        end
    end

    assign Quotient  = r_quot;
    assign Remainder = r_remd;
    assign Done      = r_done;
    assign Busy      = r_busy;
    assign DivByZero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver predicts each accepted request with an
// arithmetic model, a monitor checks results, latency, Busy and output holding.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         Clock = 1'b0;
    logic         nReset;
    logic         Req;
    logic         Signed;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Done;
    logic         Busy;
    logic         DivByZero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc_edge;
        int           done_edge;
    } exp_t;

    exp_t         exp_q[$];
    int           checks    = 0;
    int           errors    = 0;
    int           edge_n    = 0;
    int           free_edge = 0;
    int           cur_acc   = 0;
    int           cur_done  = 0;
    logic [W-1:0] last_q    = '0;
    logic [W-1:0] last_r    = '0;
    logic         last_dbz  = 1'b0;

    seq_divider #(
        .OPERAND_W (W)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .Req       (Req),
        .Signed    (Signed),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Done      (Done),
        .Busy      (Busy),
        .DivByZero (DivByZero)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Truncating division on plain integers; Done follows W+1 cycles after accept, or 1 for x/0.
    function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int acc);
        exp_t   e;
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        e.acc_edge = acc;
        if (b == '0) begin
            e.q         = '1;
            e.r         = a;
            e.dbz       = 1'b1;
            e.done_edge = acc;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            qq          = sa / sb;
            rr          = sa % sb;
            e.q         = qq[W-1:0];
            e.r         = rr[W-1:0];
            e.dbz       = 1'b0;
            e.done_edge = acc + int'(W);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h01;
            4:       return 8'h00;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Drive one cycle of inputs; predict acceptance from the bench's own notion of when the unit is free.
    task automatic drive(input bit req, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        Req      = req;
        Signed   = s;
        Operand1 = a;
        Operand2 = b;
        if (req && nReset && (edge_n + 1 >= free_edge)) begin
            e         = model(s, a, b, edge_n + 1);
            exp_q.push_back(e);
            cur_acc   = e.acc_edge;
            cur_done  = e.done_edge;
            free_edge = e.done_edge + 1;
        end
        @(posedge Clock);
        #1;
    endtask

    // Wait for the unit to free up (optionally hammering Req with junk), then present the request.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        while (edge_n + 1 < free_edge)
            drive(hold ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        drive(1'b1, s, a, b);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    initial begin : monitor
        exp_t e;
        logic busy_exp;
        forever begin
            @(negedge Clock);
            if (nReset === 1'b1) begin
                if (exp_q.size() > 0 && edge_n > exp_q[0].done_edge) begin
                    check("done_timeout", 64'(edge_n), 64'(exp_q[0].done_edge));
                    void'(exp_q.pop_front());
                end
                busy_exp = (edge_n >= cur_acc) && (edge_n < cur_done);
                check("busy", 64'(Busy), 64'(busy_exp));
                if (Done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'(Done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", 64'(edge_n), 64'(e.done_edge));
                        check("quotient", 64'(Quotient), 64'(e.q));
                        check("remainder", 64'(Remainder), 64'(e.r));
                        check("divbyzero", 64'(DivByZero), 64'(e.dbz));
                        last_q   = e.q;
                        last_r   = e.r;
                        last_dbz = e.dbz;
                    end
                end else begin
                    check("hold", 64'({DivByZero, Remainder, Quotient}),
                          64'({last_dbz, last_r, last_q}));
                end
            end
        end
    end

    initial begin : stimulus
        nReset   = 1'b0;
        Req      = 1'b0;
        Signed   = 1'b0;
        Operand1 = '0;
        Operand2 = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_outputs", 64'({Quotient, Remainder, Done, Busy, DivByZero}), 64'd0);
        nReset = 1'b1;

        issue(1'b0, 8'd200, 8'd7,   1'b0);
        issue(1'b1, 8'h9C,  8'h07,  1'b0);
        issue(1'b1, 8'd100, 8'hF9,  1'b0);
        issue(1'b0, 8'd55,  8'd0,   1'b0);
        issue(1'b1, 8'd55,  8'd0,   1'b0);
        issue(1'b0, 8'd200, 8'd7,   1'b0);
        issue(1'b1, 8'h80,  8'hFF,  1'b0);
        issue(1'b0, 8'd255, 8'd1,   1'b0);
        issue(1'b0, 8'd5,   8'd9,   1'b0);
        for (int i = 0; i < 5; i++)
            issue(1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
        repeat (3) idle();
        for (int i = 0; i < 3; i++)
            issue(1'($urandom_range(0, 1)), pick(), pick(), 1'b0);

        // Abort mid-division: nothing from the old op may surface afterwards.
        issue(1'b0, 8'd200, 8'd7, 1'b0);
        repeat (4) idle();
        nReset = 1'b0;
        #1;
        check("reset_abort_outputs", 64'({Quotient, Remainder, Done, Busy, DivByZero}), 64'd0);
        exp_q.delete();
        free_edge = 0;
        cur_acc   = 0;
        cur_done  = 0;
        last_q    = '0;
        last_r    = '0;
        last_dbz  = 1'b0;
        repeat (2) idle();
        check("reset_held_outputs", 64'({Quotient, Remainder, Done, Busy, DivByZero}), 64'd0);
        nReset = 1'b1;
        issue(1'b1, 8'h9C, 8'h07, 1'b0);

        for (int i = 0; i < 250; i++) begin
            issue(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle();
        end

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle();
        repeat (3) idle();
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
